tag_cmp_rr: RTL

TAG_CMP_RR -- requirements
Module: tag_cmp_rr

---
 rtl/tag_cmp_rr.sv | 137 +++++++++++++
 1 files changed

// File: rtl/tag_cmp_rr.sv
// Tag-compare front end: arbitrates between ports for the tag/data memories, then compares
// the stored tags of all ways against the granted port's tag one cycle later.
module tag_cmp_rr #(
  parameter int unsigned NR_PORTS   = 3,
  parameter int unsigned SET_ASSOC  = 8,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned TAG_WIDTH  = 44,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned RR_ARB     = 1
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [NR_PORTS-1:0][SET_ASSOC-1:0]      req_i,
  input  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0]     addr_i,
  input  logic [NR_PORTS-1:0][LINE_WIDTH-1:0]     wdata_i,
  input  logic [NR_PORTS-1:0]                     we_i,
  input  logic [NR_PORTS-1:0][LINE_WIDTH/8-1:0]   be_i,
  input  logic [NR_PORTS-1:0][TAG_WIDTH-1:0]      tag_i,
  output logic [NR_PORTS-1:0]                     gnt_o,
  output logic [SET_ASSOC-1:0]                    req_o,
  output logic [ADDR_WIDTH-1:0]                   addr_o,
  output logic [LINE_WIDTH-1:0]                   wdata_o,
  output logic                                    we_o,
  output logic [LINE_WIDTH/8-1:0]                 be_o,
  input  logic [SET_ASSOC-1:0][TAG_WIDTH-1:0]     rd_tag_i,
  input  logic [SET_ASSOC-1:0]                    rd_valid_i,
  output logic [SET_ASSOC-1:0]                    hit_way_o,
  output logic [(SET_ASSOC > 1 ? $clog2(SET_ASSOC) : 1)-1:0] hit_idx_o,
  output logic                                    cmp_valid_o,
  output logic [NR_PORTS-1:0]                     cmp_port_o,
  output logic                                    multi_hit_o,
  input  logic                                    clr_err_i
);

  localparam int unsigned PortW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam int unsigned IdxW  = (SET_ASSOC > 1) ? $clog2(SET_ASSOC) : 1;

  logic [PortW-1:0]     r_rr;
  logic [NR_PORTS-1:0]  r_id;
  logic                 r_multi_hit;

  logic [NR_PORTS-1:0]  w_port_req;
  logic [NR_PORTS-1:0]  w_gnt;
  logic [PortW-1:0]     w_gnt_idx;
  logic [PortW-1:0]     w_cand;
  logic                 w_any_gnt;
  logic [PortW-1:0]     w_rr_next;
  logic [TAG_WIDTH-1:0] w_sel_tag;
  logic                 w_multi;

  always_comb begin
    w_port_req = '0;
    for (int unsigned p = 0; p < NR_PORTS; p++) begin
      w_port_req[p] = |req_i[p];
    end
  end

  // Scan ports starting at the rotating pointer (or at port 0 for fixed priority).
  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_cand    = '0;
    w_any_gnt = 1'b0;
    for (int unsigned k = 0; k < NR_PORTS; k++) begin
      w_cand = (RR_ARB != 0) ? PortW'((32'(r_rr) + k) % NR_PORTS) : PortW'(k);
      if (!w_any_gnt && w_port_req[w_cand]) begin
        w_any_gnt        = 1'b1;
        w_gnt_idx        = w_cand;
        w_gnt[w_cand]    = 1'b1;
      end
    end
  end

  assign w_rr_next = (w_gnt_idx == PortW'(NR_PORTS - 1)) ? '0 : w_gnt_idx + PortW'(1);
  assign gnt_o     = w_gnt;

  always_comb begin
    req_o   = '0;
    addr_o  = '0;
    wdata_o = '0;
    we_o    = 1'b0;
    be_o    = '0;
    if (w_any_gnt) begin
      req_o   = req_i[w_gnt_idx];
      addr_o  = addr_i[w_gnt_idx];
      wdata_o = wdata_i[w_gnt_idx];
      we_o    = we_i[w_gnt_idx];
      be_o    = be_i[w_gnt_idx];
    end
  end

  assign cmp_valid_o = |r_id;
  assign cmp_port_o  = r_id;
  assign multi_hit_o = r_multi_hit;

  // r_id is one-hot or zero, so an OR-mux selects the owning port's tag.
  always_comb begin
    w_sel_tag = '0;
    for (int unsigned p = 0; p < NR_PORTS; p++) begin
      if (r_id[p]) w_sel_tag = w_sel_tag | tag_i[p];
    end
  end

  always_comb begin
    hit_way_o = '0;
    for (int unsigned w = 0; w < SET_ASSOC; w++) begin
      hit_way_o[w] = cmp_valid_o & rd_valid_i[w] & (rd_tag_i[w] == w_sel_tag);
    end
  end

  always_comb begin
    hit_idx_o = '0;
    for (int w = SET_ASSOC - 1; w >= 0; w--) begin
      if (hit_way_o[w]) hit_idx_o = IdxW'(w);
    end
  end

  // More than one bit set iff clearing the lowest set bit leaves something behind.
  assign w_multi = |(hit_way_o & (hit_way_o - SET_ASSOC'(1)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr        <= '0;
      r_id        <= '0;
      r_multi_hit <= 1'b0;
    end else begin
      if (w_any_gnt) r_rr <= w_rr_next;
      r_id <= w_gnt;
      if (w_multi) begin
        r_multi_hit <= 1'b1;
      end else if (clr_err_i) begin
        r_multi_hit <= 1'b0;
      end
    end
  end

endmodule
